matrixmac_seq: RTL and testbench
================================

Name: matrixmac_seq

Overview:
Sequencer for the HWPE matrix-MAC datapath. It starts on the same `matrixmac_st` pulse that loads H/W count and stride. It snapshots the layer configuration and a feature-map base address, then walks the output-pixel and kernel-window loops, issuing one feature-memory read address per beat with accumulator clear/last markers. It sits between the configuration register block and the FMEM read port / MAC array.

Parameters:
- `FMEM_ADDR_WIDTH`, default 16: width of feature-memory addresses. All address arithmetic is modulo 2^FMEM_ADDR_WIDTH.

Ports:
- `clk`  in  1  system clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `matrixmac_st`  in  1  start pulse, sampled only in IDLE.
- `base_sel`  in  3  FmapAddrBase index, sampled with start.
- `W_count`  in  16  output columns.
- `H_count`  in  16  output rows.
- `W_stride`  in  16  address step per output column.
- `H_stride`  in  16  input-row step per output row.
- `Conv_W_offset`  in  16  input row pitch in words.
- `Kernel_size`  in  4  kernel edge K (window is KxK).
- `baseaddr_ra1`  out  3  base-register read index.
- `baseaddr_rd1`  in  FMEM_ADDR_WIDTH  base-register read data.
- `fmem_raddr`  out  FMEM_ADDR_WIDTH  read address.
- `fmem_rvalid`  out  1  address valid.
- `fmem_rready`  in  1  consumer accepts the beat.
- `mac_clr`  out  1  beat is the first tap of a pixel.
- `mac_last`  out  1  beat is the last tap of a pixel.
- `busy`  out  1  high from LOAD through RUN.
- `done`  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: state=IDLE; `fmem_rvalid`, `mac_clr`, `mac_last`, `busy`, `done` = 0; `fmem_raddr` = 0; `baseaddr_ra1` = 0; all counters and pointers = 0.
- IDLE:
  - On `matrixmac_st`=1, latch `W_count`, `H_count`, `W_stride`, `H_stride`, `Conv_W_offset`, `Kernel_size` and `base_sel` into shadow registers. Drive `baseaddr_ra1` = latched `base_sel`. Next state LOAD.
  - Config inputs are don't-care after the start cycle.
- LOAD (1 cycle):
  - Capture `base` = `baseaddr_rd1`.
  - Compute `row_step` = `H_stride` * `Conv_W_offset`, truncated to FMEM_ADDR_WIDTH.
  - Initialise loop counters `oh`, `ow`, `ky`, `kx` = 0 and pointers `row_ptr` = `pix_ptr` = `win_ptr` = `addr` = `base`.
  - If `H_count`==0, `W_count`==0 or `Kernel_size`==0, go to DONE with zero beats issued. Otherwise go to RUN.
- RUN:
  - `fmem_rvalid`=1 and `fmem_raddr`=`addr`, where `addr` = `base` + `oh`*`row_step` + `ow`*`W_stride` + `ky`*`Conv_W_offset` + `kx`.
  - `addr` is maintained incrementally with adders only (no multiplier in RUN).
  - `mac_clr` = (`ky`==0 && `kx`==0). `mac_last` = (`ky`==K-1 && `kx`==K-1). With K=1, both are high on the same beat.
- Beat handshake:
  - A beat transfers when `fmem_rvalid` && `fmem_rready`.
  - Without transfer, `fmem_raddr`, `mac_clr` and `mac_last` hold stable.
  - One beat per cycle maximum, zero bubbles under continuous ready.
- Loop advance on transfer (kx innermost):
  - `kx`<K-1: `kx`++, `addr`++.
  - Else `ky`<K-1: `kx`=0, `ky`++, `win_ptr`+=`Conv_W_offset`, `addr`=new `win_ptr`.
  - Else `ow`<`W_count`-1: clear `kx`/`ky`, `ow`++, `pix_ptr`+=`W_stride`, `win_ptr`=`addr`=new `pix_ptr`.
  - Else `oh`<`H_count`-1: clear `kx`/`ky`/`ow`, `oh`++, `row_ptr`+=`row_step`, `pix_ptr`=`win_ptr`=`addr`=new `row_ptr`.
  - Else: final beat; next state DONE.
- DONE (1 cycle): `done`=1, `busy`=0, `fmem_rvalid`=0, next state IDLE.
- Totals: `H_count`*`W_count`*K*K beats per job; `done` follows the final transfer by exactly one cycle.
- Latency: start at cycle t; LOAD at t+1; first valid beat at t+2.
- `matrixmac_st` outside IDLE is ignored. It is not queued and has no effect on the running job.
- Address overflow wraps silently modulo 2^FMEM_ADDR_WIDTH. No error flag.
- Counters are 16-bit (4-bit for k) and compare against latched values; there is no counter overflow.
- `rst` mid-job: next cycle returns to IDLE with reset values. No `done` pulse, and any in-flight beat is dropped.
- `rst` and `matrixmac_st` in the same cycle: reset wins and the start is lost.

Test Plan:
- Basic walk:
  - Stimulus: base=0x100, H=2, W=2, K=2, W_stride=1, H_stride=1, Conv_W_offset=8, `fmem_rready`=1.
  - Required: 16 beats with addresses 100,101,108,109 / 101,102,109,10A / 108,109,110,111 / 109,10A,111,112.
  - Required: `mac_clr` on beats 0,4,8,12 and `mac_last` on beats 3,7,11,15; first beat at t+2; `done` one cycle after the last beat.
- Backpressure:
  - Stimulus: same job with `fmem_rready` toggling 1,0,0,1,...
  - Required: address, `mac_clr` and `mac_last` stable while stalled; identical 16-address sequence; no skips or duplicates.
- Degenerate sizes:
  - Stimulus 1: K=0 → required: zero beats; `done` at t+2; `busy` high only at t+1.
  - Stimulus 2: H=1, W=3, K=1, W_stride=2, base=0 → required: addresses 0,2,4, each beat with both `mac_clr` and `mac_last` set.
- Address wrap:
  - Stimulus: FMEM_ADDR_WIDTH=16, base=0xFFFE, H=W=1, K=2, Conv_W_offset=1.
  - Required: addresses FFFE,FFFF,FFFF,0000.
- Start while busy:
  - Stimulus: second `matrixmac_st` with different counts during RUN.
  - Required: ignored; the original sequence completes and exactly one `done` pulse is produced.
- Reset mid-job:
  - Stimulus: assert `rst` after beat 5.
  - Required: next cycle all outputs at reset values and no `done`. A fresh start afterwards runs the full 16-beat sequence.

Source files
------------

// File: rtl/matrixmac_seq.sv
// Address sequencer for the HWPE matrix-MAC: walks output pixels and KxK kernel
// windows, issuing one feature-memory read address per accepted beat.
module matrixmac_seq #(
  parameter int unsigned FMEM_ADDR_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       matrixmac_st,
  input  logic [2:0]                 base_sel,
  input  logic [15:0]                W_count,
  input  logic [15:0]                H_count,
  input  logic [15:0]                W_stride,
  input  logic [15:0]                H_stride,
  input  logic [15:0]                Conv_W_offset,
  input  logic [3:0]                 Kernel_size,
  output logic [2:0]                 baseaddr_ra1,
  input  logic [FMEM_ADDR_WIDTH-1:0] baseaddr_rd1,
  output logic [FMEM_ADDR_WIDTH-1:0] fmem_raddr,
  output logic                       fmem_rvalid,
  input  logic                       fmem_rready,
  output logic                       mac_clr,
  output logic                       mac_last,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned AW = FMEM_ADDR_WIDTH;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Job configuration shadows, captured on the accepted start pulse.
  logic [15:0] w_cnt_q, w_cnt_d;
  logic [15:0] h_cnt_q, h_cnt_d;
  logic [15:0] w_stride_q, w_stride_d;
  logic [15:0] h_stride_q, h_stride_d;
  logic [15:0] row_pitch_q, row_pitch_d;
  logic [3:0]  k_q, k_d;
  logic [2:0]  sel_q, sel_d;

  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] row_step_q, row_step_d;
  logic [AW-1:0] row_ptr_q, row_ptr_d;
  logic [AW-1:0] pix_ptr_q, pix_ptr_d;
  logic [AW-1:0] win_ptr_q, win_ptr_d;
  logic [AW-1:0] addr_q, addr_d;

  logic [15:0] oh_q, oh_d;
  logic [15:0] ow_q, ow_d;
  logic [3:0]  ky_q, ky_d;
  logic [3:0]  kx_q, kx_d;

  logic [31:0]   row_prod;
  logic [AW-1:0] w_step;
  logic [AW-1:0] pitch_step;
  logic [AW-1:0] pix_ptr_nxt;
  logic [AW-1:0] win_ptr_nxt;
  logic [AW-1:0] row_ptr_nxt;
  logic          run;
  logic          beat;
  logic          kx_end;
  logic          ky_end;
  logic          ow_end;
  logic          oh_end;
  logic          empty_job;

  // The only multiplier: evaluated once per job while in LOAD.
  assign row_prod    = 32'(h_stride_q) * 32'(row_pitch_q);
  assign w_step      = AW'(w_stride_q);
  assign pitch_step  = AW'(row_pitch_q);
  assign pix_ptr_nxt = pix_ptr_q + w_step;
  assign win_ptr_nxt = win_ptr_q + pitch_step;
  assign row_ptr_nxt = row_ptr_q + row_step_q;

  assign run    = (state_q == StRun);
  assign beat   = run && fmem_rready;
  assign kx_end = (kx_q == k_q - 4'd1);
  assign ky_end = (ky_q == k_q - 4'd1);
  assign ow_end = (ow_q == w_cnt_q - 16'd1);
  assign oh_end = (oh_q == h_cnt_q - 16'd1);

  assign empty_job = (h_cnt_q == 16'd0) || (w_cnt_q == 16'd0) || (k_q == 4'd0);

  always_comb begin
    state_d     = state_q;
    w_cnt_d     = w_cnt_q;
    h_cnt_d     = h_cnt_q;
    w_stride_d  = w_stride_q;
    h_stride_d  = h_stride_q;
    row_pitch_d = row_pitch_q;
    k_d         = k_q;
    sel_d       = sel_q;
    base_d      = base_q;
    row_step_d  = row_step_q;
    row_ptr_d   = row_ptr_q;
    pix_ptr_d   = pix_ptr_q;
    win_ptr_d   = win_ptr_q;
    addr_d      = addr_q;
    oh_d        = oh_q;
    ow_d        = ow_q;
    ky_d        = ky_q;
    kx_d        = kx_q;

    unique case (state_q)
      StIdle: begin
        if (matrixmac_st) begin
          w_cnt_d     = W_count;
          h_cnt_d     = H_count;
          w_stride_d  = W_stride;
          h_stride_d  = H_stride;
          row_pitch_d = Conv_W_offset;
          k_d         = Kernel_size;
          sel_d       = base_sel;
          state_d     = StLoad;
        end
      end

      StLoad: begin
        base_d     = baseaddr_rd1;
        row_step_d = AW'(row_prod);
        row_ptr_d  = baseaddr_rd1;
        pix_ptr_d  = baseaddr_rd1;
        win_ptr_d  = baseaddr_rd1;
        addr_d     = baseaddr_rd1;
        oh_d       = 16'd0;
        ow_d       = 16'd0;
        ky_d       = 4'd0;
        kx_d       = 4'd0;
        state_d    = empty_job ? StDone : StRun;
      end

      StRun: begin
        // Loops nest kx (innermost), ky, ow, oh; pointers carry each loop's origin.
        if (beat) begin
          if (!kx_end) begin
            kx_d   = kx_q + 4'd1;
            addr_d = addr_q + AW'(1);
          end else if (!ky_end) begin
            kx_d      = 4'd0;
            ky_d      = ky_q + 4'd1;
            win_ptr_d = win_ptr_nxt;
            addr_d    = win_ptr_nxt;
          end else if (!ow_end) begin
            kx_d      = 4'd0;
            ky_d      = 4'd0;
            ow_d      = ow_q + 16'd1;
            pix_ptr_d = pix_ptr_nxt;
            win_ptr_d = pix_ptr_nxt;
            addr_d    = pix_ptr_nxt;
          end else if (!oh_end) begin
            kx_d      = 4'd0;
            ky_d      = 4'd0;
            ow_d      = 16'd0;
            oh_d      = oh_q + 16'd1;
            row_ptr_d = row_ptr_nxt;
            pix_ptr_d = row_ptr_nxt;
            win_ptr_d = row_ptr_nxt;
            addr_d    = row_ptr_nxt;
          end else begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      w_cnt_q     <= '0;
      h_cnt_q     <= '0;
      w_stride_q  <= '0;
      h_stride_q  <= '0;
      row_pitch_q <= '0;
      k_q         <= '0;
      sel_q       <= '0;
      base_q      <= '0;
      row_step_q  <= '0;
      row_ptr_q   <= '0;
      pix_ptr_q   <= '0;
      win_ptr_q   <= '0;
      addr_q      <= '0;
      oh_q        <= '0;
      ow_q        <= '0;
      ky_q        <= '0;
      kx_q        <= '0;
    end else begin
      state_q     <= state_d;
      w_cnt_q     <= w_cnt_d;
      h_cnt_q     <= h_cnt_d;
      w_stride_q  <= w_stride_d;
      h_stride_q  <= h_stride_d;
      row_pitch_q <= row_pitch_d;
      k_q         <= k_d;
      sel_q       <= sel_d;
      base_q      <= base_d;
      row_step_q  <= row_step_d;
      row_ptr_q   <= row_ptr_d;
      pix_ptr_q   <= pix_ptr_d;
      win_ptr_q   <= win_ptr_d;
      addr_q      <= addr_d;
      oh_q        <= oh_d;
      ow_q        <= ow_d;
      ky_q        <= ky_d;
      kx_q        <= kx_d;
    end
  end

  // Outputs come straight from state, so they hold while a beat is stalled.
  assign baseaddr_ra1 = sel_q;
  assign fmem_raddr   = addr_q;
  assign fmem_rvalid  = run;
  assign mac_clr      = run && (ky_q == 4'd0) && (kx_q == 4'd0);
  assign mac_last     = run && kx_end && ky_end;
  assign busy         = (state_q == StLoad) || run;
  assign done         = (state_q == StDone);

endmodule

// File: tb/tb_matrixmac_seq.sv
// Scoreboard bench for matrixmac_seq: expected beats come from a direct
// closed-form address model pushed at start, compared as the DUT emits beats.
module tb_matrixmac_seq;

  logic        clk;
  logic        rst;
  logic        matrixmac_st;
  logic [2:0]  base_sel;
  logic [15:0] W_count;
  logic [15:0] H_count;
  logic [15:0] W_stride;
  logic [15:0] H_stride;
  logic [15:0] Conv_W_offset;
  logic [3:0]  Kernel_size;
  logic [2:0]  baseaddr_ra1;
  logic [15:0] baseaddr_rd1;
  logic [15:0] fmem_raddr;
  logic        fmem_rvalid;
  logic        fmem_rready;
  logic        mac_clr;
  logic        mac_last;
  logic        busy;
  logic        done;

  typedef struct {
    logic [15:0] addr;
    logic        clr;
    logic        last;
    int          cyc;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    done_c[$];
  int    busy_c[$];
  int    stall_err;
  bit    timed_out;
  int    checks;
  int    failures;

  logic [15:0] base_regs [8];

  assign baseaddr_rd1 = base_regs[baseaddr_ra1];

  matrixmac_seq #(
    .FMEM_ADDR_WIDTH(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .matrixmac_st (matrixmac_st),
    .base_sel     (base_sel),
    .W_count      (W_count),
    .H_count      (H_count),
    .W_stride     (W_stride),
    .H_stride     (H_stride),
    .Conv_W_offset(Conv_W_offset),
    .Kernel_size  (Kernel_size),
    .baseaddr_ra1 (baseaddr_ra1),
    .baseaddr_rd1 (baseaddr_rd1),
    .fmem_raddr   (fmem_raddr),
    .fmem_rvalid  (fmem_rvalid),
    .fmem_rready  (fmem_rready),
    .mac_clr      (mac_clr),
    .mac_last     (mac_last),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void push_exp(input logic [15:0] base, input int h, input int w,
                                   input int k, input int ws, input int hs, input int cwo);
    beat_t  e;
    longint a;
    for (int oh = 0; oh < h; oh++)
      for (int ow = 0; ow < w; ow++)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++) begin
            a = longint'(base) + longint'(oh) * hs * cwo + longint'(ow) * ws
                + longint'(ky) * cwo + kx;
            e.addr = a[15:0];
            e.clr  = (ky == 0) && (kx == 0);
            e.last = (ky == k - 1) && (kx == k - 1);
            e.cyc  = 0;
            exp_q.push_back(e);
          end
  endfunction

  // Pulses start at cycle t; returns at the falling edge of t+1 (LOAD cycle).
  task automatic start_job(input logic [2:0] sel, input logic [15:0] h, input logic [15:0] w,
                           input logic [3:0] k, input logic [15:0] ws, input logic [15:0] hs,
                           input logic [15:0] cwo);
    @(negedge clk);
    base_sel      = sel;
    H_count       = h;
    W_count       = w;
    Kernel_size   = k;
    W_stride      = ws;
    H_stride      = hs;
    Conv_W_offset = cwo;
    matrixmac_st  = 1'b1;
    push_exp(base_regs[sel], int'(h), int'(w), int'(k), int'(ws), int'(hs), int'(cwo));
    @(negedge clk);
    matrixmac_st  = 1'b0;
    base_sel      = 3'($urandom);
    H_count       = 16'($urandom);
    W_count       = 16'($urandom);
    Kernel_size   = 4'($urandom);
    W_stride      = 16'($urandom);
    H_stride      = 16'($urandom);
    Conv_W_offset = 16'($urandom);
  endtask

  // Records DUT activity per cycle (cycle 1 = LOAD). mode 0: ready always,
  // mode 1: ready pattern 1,0,0. Stops 4 cycles after done, or at stop_beats beats.
  task automatic collect(input int mode, input int inject_c, input int stop_beats,
                         input int max_c);
    int          c;
    int          tail;
    bit          prev_stall;
    logic [18:0] cur;
    logic [18:0] prev;
    beat_t       o;
    obs_q.delete();
    done_c.delete();
    busy_c.delete();
    stall_err  = 0;
    timed_out  = 1'b0;
    c          = 1;
    tail       = -1;
    prev_stall = 1'b0;
    prev       = '0;
    forever begin
      fmem_rready = (mode == 0) ? 1'b1 : ((c % 3) == 2);
      if (inject_c > 0) begin
        matrixmac_st = (c == inject_c);
        if (c == inject_c) begin
          H_count     = 16'd5;
          W_count     = 16'd5;
          Kernel_size = 4'd3;
          base_sel    = 3'd2;
        end
      end
      cur = {fmem_rvalid, fmem_raddr, mac_clr, mac_last};
      if (prev_stall && (cur !== prev)) stall_err++;
      prev_stall = fmem_rvalid && !fmem_rready;
      prev       = cur;
      if (busy) busy_c.push_back(c);
      if (done) begin
        done_c.push_back(c);
        if (tail < 0) tail = 4;
      end
      if (fmem_rvalid && fmem_rready) begin
        o.addr = fmem_raddr;
        o.clr  = mac_clr;
        o.last = mac_last;
        o.cyc  = c;
        obs_q.push_back(o);
      end
      if (stop_beats > 0 && obs_q.size() == stop_beats) break;
      if (tail == 0) break;
      if (tail > 0) tail--;
      if (c >= max_c) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
      c++;
    end
    matrixmac_st = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({fmem_rvalid, fmem_raddr, mac_clr, mac_last, busy, done, baseaddr_ra1} !== 24'd0)
      begin
      failures++;
      $display("FAIL reset_outputs: got rvalid=%b raddr=%h clr=%b last=%b busy=%b done=%b ra1=%0d expected all zero",
               fmem_rvalid, fmem_raddr, mac_clr, mac_last, busy, done, baseaddr_ra1);
    end
    // Reset and start in the same cycle: the start must be lost.
    matrixmac_st = 1'b1;
    base_sel     = 3'd1;
    H_count      = 16'd2;
    W_count      = 16'd2;
    Kernel_size  = 4'd2;
    @(negedge clk);
    rst          = 1'b0;
    matrixmac_st = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fmem_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_wins_start: got busy=%b rvalid=%b expected 0 0", busy, fmem_rvalid);
    end
  endtask

  task automatic test_basic();
    beat_t o;
    beat_t e;
    exp_q.delete();
    start_job(3'd1, 16'd2, 16'd2, 4'd2, 16'd1, 16'd1, 16'd8);
    collect(0, 0, 0, 200);
    checks++;
    if (timed_out || obs_q.size() != 16) begin
      failures++;
      $display("FAIL basic_beats: got %0d beats (timeout=%b) expected 16", obs_q.size(), timed_out);
    end
    checks++;
    if (obs_q.size() > 0 && obs_q[0].cyc != 2) begin
      failures++;
      $display("FAIL basic_first_beat: got cycle %0d expected cycle 2", obs_q[0].cyc);
    end
    checks++;
    if (done_c.size() != 1 || done_c[0] != 18) begin
      failures++;
      $display("FAIL basic_done: got %0d pulses first at %0d expected 1 at cycle 18",
               done_c.size(), (done_c.size() > 0) ? done_c[0] : -1);
    end
    checks++;
    if (busy_c.size() != 17 || busy_c[0] != 1) begin
      failures++;
      $display("FAIL basic_busy: got %0d busy cycles expected 17 from cycle 1", busy_c.size());
    end
    for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if ({o.addr, o.clr, o.last} !== {e.addr, e.clr, e.last}) begin
        failures++;
        $display("FAIL basic_beat%0d: got addr=%h clr=%b last=%b expected addr=%h clr=%b last=%b",
                 i, o.addr, o.clr, o.last, e.addr, e.clr, e.last);
      end
    end
  endtask

  task automatic test_backpressure();
    beat_t o;
    beat_t e;
    exp_q.delete();
    start_job(3'd1, 16'd2, 16'd2, 4'd2, 16'd1, 16'd1, 16'd8);
    collect(1, 0, 0, 300);
    checks++;
    if (timed_out || obs_q.size() != 16) begin
      failures++;
      $display("FAIL bp_beats: got %0d beats (timeout=%b) expected 16", obs_q.size(), timed_out);
    end
    checks++;
    if (stall_err != 0) begin
      failures++;
      $display("FAIL bp_stall_stable: got %0d changes while stalled expected 0", stall_err);
    end
    checks++;
    if (done_c.size() != 1 || done_c[0] != 48) begin
      failures++;
      $display("FAIL bp_done: got %0d pulses first at %0d expected 1 at cycle 48",
               done_c.size(), (done_c.size() > 0) ? done_c[0] : -1);
    end
    for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if ({o.addr, o.clr, o.last} !== {e.addr, e.clr, e.last} || o.cyc != 2 + 3 * i) begin
        failures++;
        $display("FAIL bp_beat%0d: got addr=%h clr=%b last=%b cyc=%0d expected addr=%h clr=%b last=%b cyc=%0d",
                 i, o.addr, o.clr, o.last, o.cyc, e.addr, e.clr, e.last, 2 + 3 * i);
      end
    end
  endtask

  task automatic test_degenerate();
    beat_t o;
    beat_t e;
    exp_q.delete();
    start_job(3'd1, 16'd2, 16'd2, 4'd0, 16'd1, 16'd1, 16'd8);
    collect(0, 0, 0, 50);
    checks++;
    if (obs_q.size() != 0 || done_c.size() != 1 || done_c[0] != 2) begin
      failures++;
      $display("FAIL k0_done: got %0d beats %0d done pulses first at %0d expected 0 beats done at cycle 2",
               obs_q.size(), done_c.size(), (done_c.size() > 0) ? done_c[0] : -1);
    end
    checks++;
    if (busy_c.size() != 1 || busy_c[0] != 1) begin
      failures++;
      $display("FAIL k0_busy: got %0d busy cycles expected only cycle 1", busy_c.size());
    end
    exp_q.delete();
    start_job(3'd0, 16'd1, 16'd3, 4'd1, 16'd2, 16'd1, 16'd8);
    collect(0, 0, 0, 50);
    checks++;
    if (timed_out || obs_q.size() != 3) begin
      failures++;
      $display("FAIL k1_beats: got %0d beats expected 3", obs_q.size());
    end
    for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if ({o.addr, o.clr, o.last} !== {e.addr, e.clr, e.last}) begin
        failures++;
        $display("FAIL k1_beat%0d: got addr=%h clr=%b last=%b expected addr=%h clr=%b last=%b",
                 i, o.addr, o.clr, o.last, e.addr, e.clr, e.last);
      end
    end
  endtask

  task automatic test_wrap();
    beat_t o;
    beat_t e;
    exp_q.delete();
    start_job(3'd2, 16'd1, 16'd1, 4'd2, 16'd1, 16'd1, 16'd1);
    collect(0, 0, 0, 50);
    checks++;
    if (timed_out || obs_q.size() != 4) begin
      failures++;
      $display("FAIL wrap_beats: got %0d beats expected 4", obs_q.size());
    end
    for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if ({o.addr, o.clr, o.last} !== {e.addr, e.clr, e.last}) begin
        failures++;
        $display("FAIL wrap_beat%0d: got addr=%h clr=%b last=%b expected addr=%h clr=%b last=%b",
                 i, o.addr, o.clr, o.last, e.addr, e.clr, e.last);
      end
    end
  endtask

  task automatic test_start_busy();
    beat_t o;
    beat_t e;
    exp_q.delete();
    start_job(3'd1, 16'd2, 16'd2, 4'd2, 16'd1, 16'd1, 16'd8);
    collect(0, 6, 0, 200);
    checks++;
    if (timed_out || obs_q.size() != 16 || done_c.size() != 1 || done_c[0] != 18) begin
      failures++;
      $display("FAIL busy_start: got %0d beats %0d done pulses expected 16 beats 1 done at cycle 18",
               obs_q.size(), done_c.size());
    end
    for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if ({o.addr, o.clr, o.last} !== {e.addr, e.clr, e.last}) begin
        failures++;
        $display("FAIL busy_start_beat%0d: got addr=%h expected addr=%h", i, o.addr, e.addr);
      end
    end
  endtask

  task automatic test_reset_mid_job();
    beat_t o;
    beat_t e;
    int    dones;
    exp_q.delete();
    start_job(3'd1, 16'd2, 16'd2, 4'd2, 16'd1, 16'd1, 16'd8);
    collect(0, 0, 6, 200);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({fmem_rvalid, fmem_raddr, mac_clr, mac_last, busy, done, baseaddr_ra1} !== 24'd0)
      begin
      failures++;
      $display("FAIL midreset_outputs: got rvalid=%b raddr=%h clr=%b last=%b busy=%b done=%b ra1=%0d expected all zero",
               fmem_rvalid, fmem_raddr, mac_clr, mac_last, busy, done, baseaddr_ra1);
    end
    rst   = 1'b0;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL midreset_no_done: got %0d done/busy cycles expected 0", dones);
    end
    exp_q.delete();
    start_job(3'd1, 16'd2, 16'd2, 4'd2, 16'd1, 16'd1, 16'd8);
    collect(0, 0, 0, 200);
    checks++;
    if (timed_out || obs_q.size() != 16 || done_c.size() != 1) begin
      failures++;
      $display("FAIL midreset_restart: got %0d beats %0d done expected 16 beats 1 done",
               obs_q.size(), done_c.size());
    end
    for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if ({o.addr, o.clr, o.last} !== {e.addr, e.clr, e.last}) begin
        failures++;
        $display("FAIL midreset_beat%0d: got addr=%h clr=%b last=%b expected addr=%h clr=%b last=%b",
                 i, o.addr, o.clr, o.last, e.addr, e.clr, e.last);
      end
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    matrixmac_st  = 1'b0;
    base_sel      = 3'd0;
    W_count       = 16'd0;
    H_count       = 16'd0;
    W_stride      = 16'd0;
    H_stride      = 16'd0;
    Conv_W_offset = 16'd0;
    Kernel_size   = 4'd0;
    fmem_rready   = 1'b1;
    base_regs[0]  = 16'h0000;
    base_regs[1]  = 16'h0100;
    base_regs[2]  = 16'hFFFE;
    for (int i = 3; i < 8; i++) base_regs[i] = 16'h1234 + 16'(i);

    test_reset();
    test_basic();
    test_backpressure();
    test_degenerate();
    test_wrap();
    test_start_busy();
    test_reset_mid_job();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
